gcm_dec_verify: RTL
===================

# gcm_dec_verify

Receive-side counterpart of the `gcm_aes` encryptor. It takes AAD blocks and ciphertext blocks, XORs the ciphertext with externally supplied CTR keystream blocks to recover the plaintext, and accumulates GHASH over AAD || C || lengths using a digit-serial GF(2^128) multiplier. It then compares the computed tag against the received tag. It sits between the link receiver and the shared AES core, which supplies H, E(K,J0) and the keystream.

## Interface
- `DIGIT`, default 8: multiplier bits processed per cycle; legal values are 1, 2, 4, 8, 16. One multiply takes 128/DIGIT cycles.
- `clk` input 1: the single clock.
- `i_rst_n` input 1: synchronous, active-low reset.
- `i_start` input 1: start pulse. Latches all configuration inputs in the same cycle. Accepted only in IDLE or DONE.
- `i_h` input [0:127]: hash subkey H = E(K, 0^128).
- `i_ek0` input [0:127]: E(K, J0).
- `i_tag` input [0:127]: received tag.
- `i_aad_size` input 64: AAD length in bits. Must be a multiple of 8.
- `i_cipher_text_size` input 64: ciphertext length in bits. Must be a multiple of 8.
- `i_data` input [0:127]: AAD or ciphertext block. Byte 0 is in bits [0:7].
- `i_data_valid` input 1, `o_data_ready` output 1: block handshake.
- `i_ks` input [0:127]: keystream block E(K, J0+n).
- `i_ks_valid` input 1, `o_ks_ready` output 1: keystream handshake.
- `o_plain_text` output [0:127]: recovered plaintext block.
- `o_pt_valid` output 1, `i_pt_ready` input 1: plaintext handshake.
- `o_busy` output 1: high in any state other than IDLE and DONE.
- `o_done` output 1: one-cycle pulse on entry to DONE.
- `o_tag_ok` output 1: comparison result. Valid from `o_done` until the next `i_start` or reset.

## Operation
- **States:** IDLE → AAD → CT → LEN → FIN → DONE. Side state MUL (multiply) returns to the caller state.
- **`i_start`:** latches H, EK0, tag and both sizes. Clears the accumulator X = 0. Computes block counts as ceil(size/128) for AAD and for C.
- **State after start:** AAD if the AAD count > 0; else CT if the C count > 0; else LEN.
- **AAD:** `o_data_ready` = 1. On accept: zero the bytes beyond the AAD length in the last block, set X ^= block, go to MUL.
- **CT:**
  - A block is accepted only when `i_data_valid` && `i_ks_valid` && the plaintext register is empty (or being drained in this cycle).
  - `o_data_ready` = `o_ks_ready` = that condition. Both handshakes always fire together.
  - Mask the last-block ciphertext bytes beyond the length to 0.
  - P = C_masked ^ (i_ks with the same mask).
  - P loads the output register with `o_pt_valid` = 1.
  - X ^= C_masked, then go to MUL.
- **LEN:** X ^= {aad_size[63:0], cipher_text_size[63:0]}, go to MUL, then FIN.
- **MUL:**
  - Computes X ← X·H in GF(2^128) with the GCM bit order: bit 0 is x^0 and the reduction constant is R = E1 || 0^120.
  - Processes DIGIT bits of X per cycle, starting at bit 0.
  - Both ready outputs are 0 during MUL.
- **FIN:** T = X ^ EK0; `o_tag_ok` ← (T == latched tag). Go to DONE.
- **DONE:** hold `o_tag_ok`. `i_start` restarts the block.
- **Plaintext register:** clears `o_pt_valid` when `i_pt_ready` && `o_pt_valid`. It is independent of the FSM.
  - FIN is not entered while `o_pt_valid` = 1, so the plaintext of the final block has been delivered before `o_done`.
- **Ignored / don't-care inputs:**
  - `i_start` while busy is ignored.
  - Data and keystream are ignored outside the AAD and CT states.
- **Plaintext is not withheld.** Consumers must discard it if `o_tag_ok` = 0.

## Timing
- **Reset (i_rst_n = 0 at a clk edge):**
  - State goes to IDLE and X to 0.
  - All outputs are 0: `o_data_ready`, `o_ks_ready`, `o_pt_valid`, `o_busy`, `o_done`, `o_tag_ok`, `o_plain_text`.
  - Reset mid-operation aborts with no `o_done`.
- **`i_start` at edge t:** `o_busy` = 1 and the ready outputs are valid from t+1.
- **Per-block cost:** 1 accept cycle + 128/DIGIT multiply cycles. With DIGIT=8, one block every 17 cycles.
- **Plaintext latency:** `o_pt_valid` rises on the edge after the accept edge.
- **Empty-message latency:** with zero-length AAD and C, `o_done` arrives at t + 1 (LEN) + 128/DIGIT (MUL) + 1 (FIN) + 1. With DIGIT=8, that is t+19.
- **Boundary cases:**
  - A size that is an exact multiple of 128 has no masking.
  - Sizes of 8 bits use a single masked block.
  - A 64-bit size is stored whole. The block count is 57 bits wide.
- **`i_start` and reset in the same cycle:** reset wins.

## Test plan
1. **Empty message.** Reset, then start with H=66e94bd4ef8a2c3b884cfa59ca342b2e, EK0=58e2fccefa7e3061367f1d57a4e7455a, tag=58e2fccefa7e3061367f1d57a4e7455a, sizes 0/0.
   Required: `o_done` at t+19 (DIGIT=8), `o_tag_ok`=1, no `o_pt_valid`.
2. **One full block.** Same H and EK0, C=0388dace60b6a392f328c2b971b2fe78, ks=0388dace60b6a392f328c2b971b2fe78, C size 128, tag=ab6e47d42cec13bdf53a67b21257bddf.
   Required: P = 0^128, `o_tag_ok`=1.
3. **Corrupted tag.** Repeat case 2 with the tag's last bit flipped.
   Required: P is still 0^128, `o_tag_ok`=0, `o_done` pulses once.
4. **Partial block.** Case 2 data with C size = 40 bits.
   Required: `o_plain_text` bytes 5..15 = 0. The tag matches a reference-model GHASH of the masked C.
5. **Backpressure.** Case 2 with `i_pt_ready` held 0 for 30 cycles; separately, delay `i_ks_valid` by 5 cycles relative to data.
   Required: no accept until both valids are present. `o_done` arrives only after the plaintext is drained. Results are unchanged.
6. **Reset and ignored start.** Assert reset during MUL of case 2.
   Required: all outputs are 0 on the next cycle, then a fresh case 1 passes. An `i_start` pulse while busy has no effect.

Source files
------------

// File: rtl/gcm_dec_verify.sv
// gcm_dec_verify: GCM receive path. Decrypts ciphertext with an externally
// supplied CTR keystream, runs digit-serial GHASH over AAD || C || lengths
// and compares E(K,J0) ^ GHASH against the received tag.
module gcm_dec_verify #(
    parameter int DIGIT = 8
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [0:127] i_h,
    input  logic [0:127] i_ek0,
    input  logic [0:127] i_tag,
    input  logic [63:0]  i_aad_size,
    input  logic [63:0]  i_cipher_text_size,
    input  logic [0:127] i_data,
    input  logic         i_data_valid,
    output logic         o_data_ready,
    input  logic [0:127] i_ks,
    input  logic         i_ks_valid,
    output logic         o_ks_ready,
    output logic [0:127] o_plain_text,
    output logic         o_pt_valid,
    input  logic         i_pt_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_tag_ok
);
    localparam int NCYC = 128 / DIGIT;
    // Bit 0 is x^0, so E1 in the first byte encodes 1 + x + x^2 + x^7.
    localparam logic [0:127] R = {8'hE1, 120'd0};

    typedef enum logic [2:0] {IDLE, AAD, CT, LEN, MUL, FIN, DONE} state_t;
    state_t state, state_n, ret, ret_n;

    logic [0:127] h, ek0, tag, x, z, v, z_step, v_step, blk_mask, blk;
    logic [63:0]  aad_size, ct_size;
    logic [56:0]  aad_left, ct_left;
    logic [6:0]   cnt;
    logic         start_acc, aad_acc, ct_acc, len_acc, fin_fire, mul_last, ct_ok;

    function automatic logic [56:0] blocks(input logic [63:0] size);
        return size[63:7] + {56'd0, |size[6:0]};
    endfunction

    // Keep only the bytes inside the message; a zero byte remainder means a full block.
    function automatic logic [0:127] tail_mask(input logic [63:0] size, input logic last);
        logic [0:127] m;
        for (int b = 0; b < 16; b++)
            m[8*b +: 8] = (!last || size[6:3] == 4'd0 || 4'(b) < size[6:3]) ? 8'hFF : 8'h00;
        return m;
    endfunction

    assign blk_mask = (state == CT) ? tail_mask(ct_size, ct_left == 57'd1)
                                    : tail_mask(aad_size, aad_left == 57'd1);
    assign blk      = i_data & blk_mask;
    assign mul_last = (state == MUL) && (cnt == 7'(NCYC - 1));
    assign o_busy   = !(state == IDLE || state == DONE);

    // One multiplier digit: consume DIGIT bits of X from bit 0, shifting V by x each step.
    always_comb begin
        z_step = z;
        v_step = v;
        for (int j = 0; j < DIGIT; j++) begin
            if (x[j]) z_step = z_step ^ v_step;
            v_step = v_step[127] ? ((v_step >> 1) ^ R) : (v_step >> 1);
        end
    end

    // Next-state, handshakes and per-state strobes; MUL returns to the state parked in ret.
    always_comb begin
        state_n      = state;
        ret_n        = ret;
        o_data_ready = 1'b0;
        o_ks_ready   = 1'b0;
        start_acc    = 1'b0;
        aad_acc      = 1'b0;
        ct_acc       = 1'b0;
        len_acc      = 1'b0;
        fin_fire     = 1'b0;
        ct_ok        = i_data_valid && i_ks_valid && (!o_pt_valid || i_pt_ready);
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    if (i_aad_size != 64'd0)              state_n = AAD;
                    else if (i_cipher_text_size != 64'd0) state_n = CT;
                    else                                  state_n = LEN;
                end
            end
            AAD: begin
                o_data_ready = 1'b1;
                if (i_data_valid) begin
                    aad_acc = 1'b1;
                    state_n = MUL;
                    if (aad_left != 57'd1)    ret_n = AAD;
                    else if (ct_left != 57'd0) ret_n = CT;
                    else                       ret_n = LEN;
                end
            end
            CT: begin
                o_data_ready = ct_ok;
                o_ks_ready   = ct_ok;
                if (ct_ok) begin
                    ct_acc  = 1'b1;
                    state_n = MUL;
                    ret_n   = (ct_left != 57'd1) ? CT : LEN;
                end
            end
            LEN: begin
                len_acc = 1'b1;
                state_n = MUL;
                ret_n   = FIN;
            end
            MUL: if (mul_last) state_n = ret;
            // Hold off the verdict until the last plaintext block has left.
            FIN: begin
                if (!o_pt_valid) begin
                    fin_fire = 1'b1;
                    state_n  = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            ret   <= IDLE;
        end else begin
            state <= state_n;
            ret   <= ret_n;
        end
    end

    // Configuration latch, GHASH accumulator and multiplier, tag verdict.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            h        <= '0;
            ek0      <= '0;
            tag      <= '0;
            aad_size <= '0;
            ct_size  <= '0;
            aad_left <= '0;
            ct_left  <= '0;
            x        <= '0;
            z        <= '0;
            v        <= '0;
            cnt      <= '0;
            o_done   <= 1'b0;
            o_tag_ok <= 1'b0;
        end else begin
            o_done <= fin_fire;
            if (start_acc) begin
                h        <= i_h;
                ek0      <= i_ek0;
                tag      <= i_tag;
                aad_size <= i_aad_size;
                ct_size  <= i_cipher_text_size;
                aad_left <= blocks(i_aad_size);
                ct_left  <= blocks(i_cipher_text_size);
                x        <= '0;
                o_tag_ok <= 1'b0;
            end
            if (aad_acc || ct_acc || len_acc) begin
                x   <= x ^ (len_acc ? {aad_size, ct_size} : blk);
                z   <= '0;
                v   <= h;
                cnt <= '0;
            end
            if (aad_acc) aad_left <= aad_left - 57'd1;
            if (ct_acc)  ct_left  <= ct_left - 57'd1;
            if (state == MUL) begin
                z   <= z_step;
                v   <= v_step;
                cnt <= cnt + 7'd1;
                x   <= mul_last ? z_step : (x << DIGIT);
            end
            if (fin_fire) o_tag_ok <= ((x ^ ek0) == tag);
        end
    end

    // Plaintext output register, drained by its own handshake.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            o_pt_valid   <= 1'b0;
            o_plain_text <= '0;
        end else if (ct_acc) begin
            o_plain_text <= blk ^ (i_ks & blk_mask);
            o_pt_valid   <= 1'b1;
        end else if (i_pt_ready && o_pt_valid) begin
            o_pt_valid <= 1'b0;
        end
    end
endmodule
